verify_arbiter: RTL
===================

VERIFY_ARBITER -- requirements
Module: verify_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters.
REQ-002 SHALL have parameter MAX_FAILS, default 3, consecutive failures that trigger lockout.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 16, lockout duration in clk cycles.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready  out  N_REQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port req_data  in  N_REQ*32  records; slice i = {region[31:24], auth_level[23:16], expiry[15:8], signature_id[7:0]}.
REQ-009 SHALL have port resp_valid  out  N_REQ  verdict valid, one-hot or zero.
REQ-010 SHALL have port resp_pass  out  1  verdict; 1 = match.
REQ-011 SHALL have port resp_ready  in  N_REQ  per-requester verdict accept.
REQ-012 SHALL have ports m_region, m_auth_level, m_expiry, m_signature_id  out  8 each  fields to shared matcher.
REQ-013 SHALL have port m_match  in  1  matcher result, registered, 1-cycle latency.
REQ-014 SHALL have port locked  out  N_REQ  requester i in lockout.
REQ-015 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one cycle each except RESP.
REQ-017 In IDLE, eligible = req_valid & ~locked; SHALL grant one eligible requester round-robin, starting search at (last_grant+1) mod N_REQ; last_grant resets to N_REQ-1.
REQ-018 SHALL assert req_ready only in IDLE, only for the granted requester; on valid&ready, SHALL latch its record and index, go to ISSUE.
REQ-019 SHALL drive m_* from the latched record at all times (zero after reset until first accept).
REQ-020 WAIT SHALL capture m_match into result register at end of WAIT.
REQ-021 RESP SHALL assert resp_valid[g] and resp_pass = result, held stable until resp_ready[g]; on handshake go to IDLE.
REQ-022 Latency: accept at edge T; resp_valid high from cycle T+3; minimum 4 cycles per transaction.
REQ-023 At WAIT capture: pass clears fail_cnt[g]; fail increments fail_cnt[g]; reaching MAX_FAILS loads lock_timer[g] = LOCKOUT_CYCLES and clears fail_cnt[g].
REQ-024 locked[i] = (lock_timer[i] != 0); each nonzero timer decrements by 1 per cycle, independent of FSM state.
REQ-025 Requester whose timer reaches 0 at edge T SHALL be eligible in cycle T; a locked requester's verdict in flight SHALL still be delivered.
REQ-026 No eligible requester in IDLE: SHALL stay IDLE, req_ready all zero.
REQ-027 req_valid dropping while in ISSUE/WAIT/RESP SHALL not affect the in-flight transaction.
REQ-028 fail_cnt width SHALL be $clog2(MAX_FAILS+1); lock_timer width $clog2(LOCKOUT_CYCLES+1).

Reset
REQ-029 rst SHALL force IDLE, clear req_ready, resp_valid, resp_pass, result, fail_cnt, lock_timer, latched record; busy=0, locked=0.
REQ-030 rst mid-transaction SHALL discard it without any response.

Structure
REQ-031 Shared package sigver_pkg SHALL hold the record struct (region, auth_level, expiry, signature_id), FSM state enum, and field width constants.
REQ-032 Round-robin grant logic SHALL be sub-module rr_arbiter (request vector, pointer in; one-hot grant out).

Verification
REQ-033 Req0 sends 0x0A0110F3, matcher model returns 1 -> req_ready[0] at T, resp_valid[0] at T+3, resp_pass=1.
REQ-034 Req0..3 valid continuously, all pass -> grants ordered 0,1,2,3,0; no requester starved.
REQ-035 Req2 sends 0x0A0110F4 three times (fails) -> locked[2] high for exactly 16 cycles after third WAIT; req_ready[2] never asserted meanwhile; req1 still served.
REQ-036 Req1 fails twice then passes, then fails twice -> no lockout (fail_cnt cleared by pass).
REQ-037 resp_ready[0] held low 10 cycles in RESP -> resp_valid[0], resp_pass stable; no new req_ready until handshake.
REQ-038 rst asserted during WAIT -> next cycle IDLE, no resp_valid, locked/fail counters zero.

Source files
------------

// File: rtl/sigver_pkg.sv
// Shared types and constants for the signature-verification arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: record field widths, the packed request record, and the
// controller state encoding.
package sigver_pkg;

  localparam int FIELD_W = 8;
  localparam int REC_W   = 4 * FIELD_W;

  // Field order matches the bus slice layout: region occupies the top byte.
  typedef struct packed {
    logic [FIELD_W-1:0] region;
    logic [FIELD_W-1:0] auth_level;
    logic [FIELD_W-1:0] expiry;
    logic [FIELD_W-1:0] signature_id;
  } sig_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is zero when no request bit is set.
//
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index where the search starts (highest priority this cycle)
//   grant - one-hot grant, or zero
module rr_arbiter
  import sigver_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/verify_arbiter.sv
// Arbitrates N requesters onto one shared signature matcher and enforces
// per-requester lockout after repeated failures.
// Latency: accept at edge T, verdict valid after edge T+2; 4 cycles minimum per transaction.
// Backpressure: verdict held until resp_ready of the granted requester; no new grant meanwhile.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_valid/ready   - per-requester request handshake (ready one-hot, IDLE only)
//   req_data          - N_REQ packed 32-bit records
//   resp_valid/ready  - per-requester verdict handshake; resp_pass is the verdict
//   m_*               - fields to the shared matcher; m_match is its registered result
//   locked            - per-requester lockout flags
//   busy              - controller is mid-transaction
module verify_arbiter
  import sigver_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*32-1:0]  req_data,
  output logic [N_REQ-1:0]     resp_valid,
  output logic                 resp_pass,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [7:0]           m_region,
  output logic [7:0]           m_auth_level,
  output logic [7:0]           m_expiry,
  output logic [7:0]           m_signature_id,
  input  logic                 m_match,
  output logic [N_REQ-1:0]     locked,
  output logic                 busy
);

  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int LTW = $clog2(LOCKOUT_CYCLES + 1);

  arb_state_t       state;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gidx;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] cur_oh;     // requester owning the in-flight transaction
  sig_rec_t         rec;        // latched record, drives the matcher
  sig_rec_t         sel_rec;
  logic             result;

  logic [FCW-1:0]   fail_cnt   [N_REQ];
  logic [LTW-1:0]   lock_timer [N_REQ];

  // ------------------------------------------------------------------
  // Grant selection
  // ------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      locked[i] = (lock_timer[i] != '0);
    end
  end

  assign eligible = req_valid & ~locked;
  assign ptr      = (last_grant == IW'(N_REQ - 1)) ? '0 : last_grant + 1'b1;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gidx    = '0;
    sel_rec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gidx    = IW'(i);
        sel_rec = sig_rec_t'(req_data[i*REC_W +: REC_W]);
      end
    end
  end

  // Ready is combinational so a request can be taken in the same IDLE
  // cycle it appears; it is masked during reset so a held reset never
  // looks like an accept to the requester.
  assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;

  // ------------------------------------------------------------------
  // Transaction controller
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= IW'(N_REQ - 1);
      cur_oh     <= '0;
      rec        <= '0;
      result     <= 1'b0;
      resp_valid <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_ready) begin
            rec        <= sel_rec;
            cur_oh     <= grant;
            last_grant <= gidx;
            state      <= ST_ISSUE;
          end
        end
        // Matcher samples m_* at the end of ISSUE and answers during WAIT.
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          result     <= m_match;
          resp_valid <= cur_oh;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (|(resp_ready & cur_oh)) begin
            resp_valid <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Failure tracking and lockout timers
  // ------------------------------------------------------------------
  // Timers run every cycle regardless of controller state. A load on the
  // failing requester overrides its decrement (the requester was eligible
  // when granted, so its timer is idle at that point anyway).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        fail_cnt[i]   <= '0;
        lock_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (lock_timer[i] != '0) begin
          lock_timer[i] <= lock_timer[i] - 1'b1;
        end
        if (state == ST_WAIT && cur_oh[i]) begin
          if (m_match) begin
            fail_cnt[i] <= '0;
          end else if (fail_cnt[i] == FCW'(MAX_FAILS - 1)) begin
            fail_cnt[i]   <= '0;
            lock_timer[i] <= LTW'(LOCKOUT_CYCLES);
          end else begin
            fail_cnt[i] <= fail_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign resp_pass      = result;
  assign busy           = (state != ST_IDLE);
  assign m_region       = rec.region;
  assign m_auth_level   = rec.auth_level;
  assign m_expiry       = rec.expiry;
  assign m_signature_id = rec.signature_id;

endmodule
